fp_to_fixed: RTL
================

Name: fp_to_fixed

Overview:
- Iterative converter from the 27-bit custom float to a signed two's-complement fixed-point word.
- It is the decode direction for fp_* arithmetic results. It sits between the gravity datapath and the position/velocity integrators and debug readback, which need plain fixed point.
- Valid/ready on both sides. Shifts one bit position per clock to keep area small.

Parameters:
INT_W, 32, integer bits of output, sign bit included
FRAC_W, 16, fraction bits of output; output width W = INT_W+FRAC_W (default 48); W must be at least 21

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  converter can accept
in_data  input  27  float: [26] sign, [25:18] exponent (bias 127), [17:0] mantissa with hidden 1
out_valid  output  1  out_data/out_ovf valid
out_ready  input  1  consumer accepts
out_data  output  W  signed fixed-point result
out_ovf  output  1  result saturated

Behaviour:
- Interface: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0. Internal shift register, counter and flags are cleared.
- Value definitions:
  - Input value = (-1)^s * 1.m * 2^(e-127).
  - mag = {1'b1,m} (19 bits).
  - sh = e - 145 + FRAC_W (signed, computed at accept).
- Accept: an edge with in_valid && in_ready. Registers sign, mag, dir = (sh<0), cnt = |sh|, and the class flags, then goes to SHIFT.
- Class flags, decided at accept:
  - ZERO: e==0. The mantissa is ignored. The result is 0, never negative zero; sign is ignored.
  - OVF: e==255, or sh > W-2-18. The result saturates to +(2^(W-1)-1) if s==0, else -2^(W-1). out_ovf=1.
  - UNF: sh <= -19. The result is 0 and out_ovf=0.
  - ZERO/OVF/UNF force cnt=0.
- States:
  - IDLE: in_ready=1. Moves to SHIFT on accept.
  - SHIFT: in_ready=0. While cnt!=0, each edge shifts mag by one bit (left if !dir, right if dir; right shift truncates) and decrements cnt. When cnt==0, the next edge loads out_data, sets out_valid=1 and moves to DONE. out_data is the sat/zero value for the flagged classes, else +mag if s==0 or -mag if s==1. Negation is two's complement at width W, so the result truncates toward zero.
  - DONE: out_valid held and out_data/out_ovf stable until an edge with out_ready=1. That edge clears out_valid and returns to IDLE; in_ready=1 in the following cycle.
- Latency and throughput:
  - Latency: out_valid rises |sh|+1 edges after the accept edge. Flagged classes take exactly 1 edge.
  - Worst normal-path latency is W-19 edges (29 for defaults).
  - One conversion in flight. No new input is accepted until the output is consumed.
- Boundary conditions:
  - in_valid while busy is ignored (in_ready=0). The upstream block must hold its data.
  - out_ready high while out_valid=0 has no effect.
  - -2^(W-1) is reached only via OVF with s==1, and reports out_ovf=1.
  - rst_n low at any time, including mid-SHIFT or in DONE, asynchronously returns everything to reset values. The in-flight conversion is discarded and nothing is output after release.
- Width: the shift register is W bits. Left shifts cannot lose bits because of the OVF pre-check.

Test Plan:
- 1.0 (in_data=0x1FC0000: s0, e127, m0), accept at edge T, out_ready=1 -> out_valid at T+3, out_data=0x0000_0001_0000, out_ovf=0; in_ready=1 after consume.
- -2.5 (s1, e128, m=0x10000, i.e. in_data=0x6010000) -> sh=-1, out_valid at T+2, out_data=0xFFFF_FFFD_8000.
- Boundaries:
  - e=157, m0 (2^30) -> out_valid at T+29, out_data=0x4000_0000_0000, ovf=0.
  - e=158 -> out_valid at T+1, out_data=0x7FFF_FFFF_FFFF, ovf=1.
  - s1, e=200 -> 0x8000_0000_0000, ovf=1.
  - e=255 -> saturate, ovf=1.
- Small and zero:
  - e=111, m0 -> out_data=1 after 19 edges.
  - e=110 -> 0 at T+1.
  - s1, e0, m=0x3FFFF -> 0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing in_data -> out_data stable, in_ready=0, no second accept. Raise out_ready -> next accept one cycle after the consume edge.
- Reset: assert rst_n=0 mid-SHIFT of a 29-cycle conversion -> outputs immediately return to reset values. After release, no spurious out_valid; a new 1.0 conversion yields 0x1_0000.

Source files
------------

// File: rtl/fp_to_fixed_if.sv
// Valid/ready bundle between a float producer, the converter and a fixed-point consumer.
// W is the fixed-point output width and must match the converter's INT_W+FRAC_W.
interface fp_to_fixed_if #(
  parameter int W = 48
);
  logic         in_valid;
  logic         in_ready;
  logic [26:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf
  );
endinterface

// File: rtl/fp_to_fixed.sv
// Iterative 27-bit float to signed fixed-point converter, one bit of shift per clock.
// Out-of-range inputs are classified at accept, so the shift loop only handles in-range values.
module fp_to_fixed #(
  parameter int INT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_to_fixed_if.slave bus
);
  localparam int W     = INT_W + FRAC_W;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic             dir_q, dir_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [18:0] in_mag;
  int          sh;
  int          sh_abs;
  logic        cls_zero, cls_ovf, cls_unf;

  assign in_sign = bus.in_data[26];
  assign in_exp  = bus.in_data[25:18];
  assign in_mag  = {1'b1, bus.in_data[17:0]};

  // Shift distance that places the 19-bit magnitude's LSB at the fixed-point LSB.
  assign sh     = int'(in_exp) - 145 + FRAC_W;
  assign sh_abs = (sh < 0) ? -sh : sh;

  // A left shift past W-20 would push the hidden bit into the sign bit.
  assign cls_zero = (in_exp == 8'd0);
  assign cls_ovf  = !cls_zero && ((in_exp == 8'hFF) || (sh > W - 2 - 18));
  assign cls_unf  = !cls_zero && !cls_ovf && (sh <= -19);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      dir_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      dir_q       <= dir_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    dir_d       = dir_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = in_sign;
          dir_d   = (sh < 0);
          ovf_d   = cls_ovf;
          zero_d  = cls_zero || cls_unf;
          shreg_d = {{(W-19){1'b0}}, in_mag};
          cnt_d   = (cls_zero || cls_ovf || cls_unf) ? '0 : CNT_W'(sh_abs);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          out_valid_d = 1'b1;
          out_ovf_d   = ovf_q;
          if (ovf_q) begin
            out_data_d = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end else if (zero_q) begin
            out_data_d = '0;
          end else begin
            // Truncating right shift then negating gives round-toward-zero for negatives.
            out_data_d = sign_q ? (W'(0) - shreg_q) : shreg_q;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule
